wshb_mire: RTL and testbench
============================

WSHB_MIRE -- requirements
Module: wshb_mire

Interface
REQ-001 Parameter HDISP, default 800, active pixels per line.
REQ-002 Parameter VDISP, default 480, active lines per frame.
REQ-003 Parameter BURST, default 64, acked writes per bus tenure before cyc is released; legal range 1..1024.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 wshb_cyc  out  1  Wishbone bus cycle.
REQ-007 wshb_stb  out  1  Wishbone strobe.
REQ-008 wshb_adr  out  32  byte address.
REQ-009 wshb_we  out  1  write enable.
REQ-010 wshb_dat_ms  out  32  write data.
REQ-011 wshb_sel  out  4  byte lanes.
REQ-012 wshb_cti  out  3  cycle type.
REQ-013 wshb_bte  out  2  burst type.
REQ-014 wshb_ack  in  1  slave acknowledge.
REQ-015 wshb_err  in  1  slave error.
REQ-016 wshb_rty  in  1  slave retry request.
REQ-017 wshb_dat_sm  in  32  read data; ignored.
REQ-018 frame_done  out  1  one-cycle pulse when the last pixel of a frame is acked.

Function
REQ-019 Block SHALL be a write-only master filling an HDISP x VDISP framebuffer, one 32-bit word per pixel, raster order, frames repeated without end.
REQ-020 Constant outputs SHALL be: wshb_we=1, wshb_sel=4'hF, wshb_cti=3'b000 (classic), wshb_bte=2'b00.
REQ-021 Counters: x (0..HDISP-1), y (0..VDISP-1), adr (byte address), bcnt (0..BURST-1); adr SHALL be incremented by 4 per accepted pixel, not computed by multiplication.
REQ-022 Pixel data SHALL be 32'h00FFFFFF when x[3:0]==0 or y[3:0]==0, else 32'h00000000 (16-pixel white grid on black).
REQ-023 Address SHALL be 4*(y*HDISP+x) for the pixel currently presented.
REQ-024 FSM states: IDLE, WRITE, PAUSE.
REQ-025 IDLE: cyc=stb=0; next cycle SHALL go to WRITE unconditionally.
REQ-026 WRITE: cyc=stb=1, adr/dat_ms from current counters, held stable until the cycle ends.
REQ-027 In WRITE, ack SHALL advance the pixel: x+1; at x==HDISP-1, x=0 and y+1; at y==VDISP-1 and x==HDISP-1, x=y=adr=0 and frame_done=1 in that same cycle.
REQ-028 In WRITE, ack with bcnt==BURST-1 SHALL clear bcnt and go to PAUSE; otherwise bcnt+1 and stay in WRITE.
REQ-029 PAUSE: cyc=stb=0 for exactly one cycle, then WRITE; this SHALL give a downstream arbiter the chance to hand the bus to another master.
REQ-030 A new access SHALL be issued back-to-back: pixel n+1 presented in the cycle after ack of pixel n, except after a PAUSE.
REQ-031 rty (without ack) SHALL leave counters unchanged, go to PAUSE, and re-present the same pixel afterwards; bcnt unchanged.
REQ-032 err (without ack) SHALL be treated as ack (pixel skipped, counters advance) so the frame never stalls.
REQ-033 Simultaneous ack with err or rty: ack SHALL take priority.
REQ-034 Slave wait states SHALL be unbounded; outputs stay stable while ack/err/rty are low.
REQ-035 frame_done SHALL be a registered-free combinational pulse of width exactly one clk, never asserted outside WRITE.

Reset
REQ-036 rst_n low SHALL asynchronously force: state=IDLE, x=y=adr=bcnt=0, cyc=stb=0, frame_done=0.
REQ-037 rst_n low mid-access SHALL abandon the cycle immediately; after release the first access SHALL be adr=0, dat_ms=32'h00FFFFFF.
REQ-038 Outputs are undefined-free: every output SHALL have a known value in and after reset.

Verification
REQ-039 Reset release, ack always high -> cyc rises 1 cycle after release, first adr=0 data=32'h00FFFFFF, second adr=4 data=32'h00000000.
REQ-040 BURST=64, ack always high -> exactly 64 acked writes, cyc low exactly one cycle, 65th write at adr=256.
REQ-041 Line wrap: ack pixel x=799,y=0 -> next adr=3200 (x=0,y=1), data=32'h00FFFFFF.
REQ-042 Frame wrap: ack pixel (799,479) -> frame_done high that cycle only, next adr=0.
REQ-043 rty on adr=40 -> one PAUSE cycle, adr=40 re-presented, bcnt unchanged; err on adr=44 -> next adr=48.
REQ-044 rst_n low with stb high at adr=1000 and 3 wait states -> cyc=0 immediately; after release first adr=0.

Source files
------------

// File: rtl/wshb_mire.sv
// wshb_mire: Wishbone write-only master that paints a 16-pixel white grid on
// black into an HDISP x VDISP framebuffer, one 32-bit word per pixel, in raster
// order, forever. The bus is released for one cycle after every BURST accepted
// writes, and after every retry, so that an arbiter can regrant it.
module wshb_mire #(
    parameter int unsigned HDISP = 800,
    parameter int unsigned VDISP = 480,
    parameter int unsigned BURST = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic [31:0] wshb_adr,
    output logic        wshb_we,
    output logic [31:0] wshb_dat_ms,
    output logic [3:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    input  logic        wshb_ack,
    input  logic        wshb_err,
    input  logic        wshb_rty,
    input  logic [31:0] wshb_dat_sm,
    output logic        frame_done
);

    // Counters are at least 4 bits wide so the grid test on [3:0] is always legal.
    localparam int unsigned XW = ($clog2(HDISP) > 4) ? $clog2(HDISP) : 4;
    localparam int unsigned YW = ($clog2(VDISP) > 4) ? $clog2(VDISP) : 4;
    localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StPause = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [31:0]     adr_q;
    logic [BW-1:0]   bcnt_q;

    logic            accept;
    logic            retry;
    logic            last_x;
    logic            last_y;
    logic            last_b;

    // Read data is never used by a write-only master.
    logic            unused_dat;
    assign unused_dat = ^wshb_dat_sm;

    // err is folded into ack so a faulty slave can never stall the frame.
    assign accept = (state_q == StWrite) && (wshb_ack || wshb_err);
    assign retry  = (state_q == StWrite) && !wshb_ack && !wshb_err && wshb_rty;
    assign last_x = (x_q == XW'(HDISP - 1));
    assign last_y = (y_q == YW'(VDISP - 1));
    assign last_b = (bcnt_q == BW'(BURST - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StWrite;
            StWrite: begin
                if ((accept && last_b) || retry) begin
                    state_d = StPause;
                end
            end
            StPause: state_d = StWrite;
            default: state_d = StIdle;
        endcase
    end

    // Pixel, address and burst counters advance only on an accepted write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            adr_q  <= '0;
            bcnt_q <= '0;
        end else if (accept) begin
            if (last_x) begin
                x_q <= '0;
                if (last_y) begin
                    y_q   <= '0;
                    adr_q <= '0;
                end else begin
                    y_q   <= y_q + 1'b1;
                    adr_q <= adr_q + 32'd4;
                end
            end else begin
                x_q   <= x_q + 1'b1;
                adr_q <= adr_q + 32'd4;
            end
            bcnt_q <= last_b ? '0 : bcnt_q + 1'b1;
        end
    end

    // Bus outputs and the end-of-frame pulse
    always_comb begin
        wshb_cyc    = (state_q == StWrite);
        wshb_stb    = (state_q == StWrite);
        wshb_adr    = adr_q;
        wshb_dat_ms = ((x_q[3:0] == 4'd0) || (y_q[3:0] == 4'd0)) ? 32'h00FF_FFFF : 32'h0000_0000;
        wshb_we     = 1'b1;
        wshb_sel    = 4'hF;
        wshb_cti    = 3'b000;
        wshb_bte    = 2'b00;
        frame_done  = accept && last_x && last_y;
    end

endmodule

// File: tb/tb_wshb_mire.sv
// Bench for wshb_mire: directed vector table after reset, randomized slave
// responses against a pixel-index model, and a reset-mid-access sequence.
module tb_wshb_mire;

    localparam int unsigned H     = 40;
    localparam int unsigned V     = 24;
    localparam int unsigned B     = 64;
    localparam int unsigned FRAME = H * V;
    localparam logic [31:0] WHITE = 32'h00FF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_ms, dat_sm;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack, err, rty;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    wshb_mire #(
        .HDISP(H),
        .VDISP(V),
        .BURST(B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wshb_cyc   (cyc),
        .wshb_stb   (stb),
        .wshb_adr   (adr),
        .wshb_we    (we),
        .wshb_dat_ms(dat_ms),
        .wshb_sel   (sel),
        .wshb_cti   (cti),
        .wshb_bte   (bte),
        .wshb_ack   (ack),
        .wshb_err   (err),
        .wshb_rty   (rty),
        .wshb_dat_sm(dat_sm),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Grid rule from the pixel index: white on every 16th column and row.
    function automatic logic [31:0] pix(input int n);
        int px;
        int py;
        px = n % H;
        py = n / H;
        return ((px % 16) == 0 || (py % 16) == 0) ? WHITE : 32'h0;
    endfunction

    typedef struct {
        bit ack;
        bit err;
        bit rty;
        bit cyc;
        int pixel;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit a, input bit e, input bit r, input bit c, input int p);
        vec_t v;
        v.ack = a; v.err = e; v.rty = r; v.cyc = c; v.pixel = p;
        tbl.push_back(v);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ack = 1'b0; err = 1'b0; rty = 1'b0;
        #1;
        check("rst_cyc", cyc, 1'b0);
        check("rst_done", frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int  n;
        int  acks;
        bit  on;
        bit  exp_done;
        int  done_exp;
        int  done_act;
        int  r;
        bit  found;

        rst_n  = 1'b0;
        ack    = 1'b0;
        err    = 1'b0;
        rty    = 1'b0;
        dat_sm = 32'hDEAD_BEEF;
        #2;
        check("rst_cyc0", cyc, 1'b0);
        check("rst_stb0", stb, 1'b0);
        check("rst_adr0", adr, 32'd0);
        check("rst_done0", frame_done, 1'b0);
        check("const_we", we, 1'b1);
        check("const_sel", sel, 4'hF);
        check("const_cti", cti, 3'b000);
        check("const_bte", bte, 2'b00);

        // Directed vectors: idle, first writes, wait state, rty at 40, err at 44,
        // and the pause after the 64th accepted write of the tenure.
        add(0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0);
        add(0, 0, 0, 1, 1);
        add(1, 0, 0, 1, 1);
        for (int p = 2; p <= 9; p++) add(1, 0, 0, 1, p);
        add(0, 0, 1, 1, 10);
        add(0, 0, 0, 0, 10);
        add(1, 0, 1, 1, 10);
        add(0, 1, 0, 1, 11);
        for (int p = 12; p <= 63; p++) add(1, 0, 0, 1, p);
        add(0, 0, 0, 0, 64);
        add(0, 0, 0, 1, 64);
        add(0, 0, 0, 1, 64);

        @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            ack = tbl[i].ack; err = tbl[i].err; rty = tbl[i].rty;
            #1;
            check($sformatf("tbl%0d_cyc", i), cyc, tbl[i].cyc);
            check($sformatf("tbl%0d_stb", i), stb, tbl[i].cyc);
            if (tbl[i].cyc) begin
                check($sformatf("tbl%0d_adr", i), adr, 32'(4 * tbl[i].pixel));
                check($sformatf("tbl%0d_dat", i), dat_ms, pix(tbl[i].pixel));
            end
            check($sformatf("tbl%0d_done", i), frame_done, 1'b0);
            @(negedge clk);
        end

        // Randomized slave against a pixel-index model; idle and pause both last
        // exactly one cycle, so the model only tracks whether the bus is held.
        do_reset();
        n = 0; acks = 0; on = 1'b0; done_exp = 0; done_act = 0;
        for (int c = 0; c < 4000; c++) begin
            r   = $urandom_range(0, 99);
            ack = (r < 70);
            err = (r >= 70 && r < 76) || (ack && $urandom_range(0, 9) == 0);
            rty = (r >= 76 && r < 82) || (ack && $urandom_range(0, 9) == 0);
            #1;
            check("rnd_cyc", cyc, on);
            check("rnd_stb", stb, on);
            if (on) begin
                check("rnd_adr", adr, 32'(4 * n));
                check("rnd_dat", dat_ms, pix(n));
            end
            exp_done = on && (ack || err) && (n == FRAME - 1);
            check("rnd_done", frame_done, exp_done);
            if (exp_done) done_exp++;
            if (frame_done) done_act++;
            if (on) begin
                if (ack || err) begin
                    n = (n + 1) % FRAME;
                    acks++;
                    if (acks == B) begin
                        acks = 0;
                        on   = 1'b0;
                    end
                end else if (rty) begin
                    on = 1'b0;
                end
            end else begin
                on = 1'b1;
            end
            @(negedge clk);
        end
        check("rnd_frame_count", done_act, done_exp);

        // Ack always high up to adr 1000, then 3 wait states and a reset mid-access.
        do_reset();
        ack = 1'b0; err = 1'b0; rty = 1'b0;
        #1;
        check("c_idle", cyc, 1'b0);
        @(negedge clk);
        found = 1'b0;
        ack   = 1'b1;
        for (int c = 0; c < 400 && !found; c++) begin
            #1;
            if (cyc && adr == 32'(4 * H)) check("c_linewrap_dat", dat_ms, WHITE);
            if (cyc && adr == 32'd1000) begin
                found = 1'b1;
                ack   = 1'b0;
            end
            @(negedge clk);
        end
        check("c_reach_1000", found, 1'b1);
        for (int w = 0; w < 2; w++) begin
            #1;
            check("c_wait_cyc", cyc, 1'b1);
            check("c_wait_adr", adr, 32'd1000);
            @(negedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("c_abandon_cyc", cyc, 1'b0);
        check("c_abandon_stb", stb, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("c_post_idle", cyc, 1'b0);
        @(negedge clk);
        #1;
        check("c_post_cyc", cyc, 1'b1);
        check("c_post_adr", adr, 32'd0);
        check("c_post_dat", dat_ms, WHITE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
